gpio_cfg_receiver: RTL and testbench

Per-pad receiver at the far end of the GPIO serial configuration chain. It consumes serial_clock, serial_resetn and serial_data from the management-side serial loader (or from the previous receiver in the chain). It shifts configuration bits into a CTRL_BITS shift register and forwards the shifted-out bits to the next pad. On a load strobe it commits the word into the active pad configuration, which then drives the mgmt/user pad muxing.

---
 rtl/gpio_cfg_receiver.sv | 118 +++++++++++
 tb/tb_gpio_cfg_receiver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_receiver.sv
// gpio_cfg_receiver: per-pad serial configuration chain receiver with mgmt/user pad muxing.
// Optional frame-length checking with sticky cfg_error is enabled by defining GPIO_CFG_FRAME_CHECK_EN.
module gpio_cfg_receiver #(
    parameter int                   CTRL_BITS   = 13,
    parameter logic [CTRL_BITS-1:0] DEFAULT_CFG = 13'h1803,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 serial_clock_in,
    input  logic                 serial_resetn_in,
    input  logic                 serial_data_in,
    output logic                 serial_clock_out,
    output logic                 serial_resetn_out,
    output logic                 serial_data_out,
    output logic [CTRL_BITS-1:0] cfg_word,
    output logic                 load_pulse,
`ifdef GPIO_CFG_FRAME_CHECK_EN
    output logic                 cfg_error,
`endif
    input  logic                 mgmt_gpio_out,
    output logic                 mgmt_gpio_in,
    input  logic                 user_gpio_out,
    input  logic                 user_gpio_oeb,
    output logic                 user_gpio_in,
    input  logic                 pad_gpio_in,
    output logic                 pad_gpio_out,
    output logic                 pad_gpio_outenb
);
    logic [SYNC_STAGES-1:0] sclk_sync_q, srst_sync_q, sdat_sync_q;
    logic                   sclk, srst, sdat;
    logic                   sclk_prev_q, srst_prev_q;
    logic                   rise, fall_rst, load, clear, commit;
    logic [CTRL_BITS-1:0]   shift_q, shift_d, shift_post, cfg_q, cfg_d;
    logic                   data_out_q, pulse_q;
    logic                   mgmt_ena, oeb;
`ifdef GPIO_CFG_FRAME_CHECK_EN
    localparam int cnt_w = $clog2(CTRL_BITS);
    logic [cnt_w-1:0] cnt_q, cnt_d, cnt_post;
    logic             err_q, err_d;
`endif

    assign sclk = sclk_sync_q[SYNC_STAGES-1];
    assign srst = srst_sync_q[SYNC_STAGES-1];
    assign sdat = sdat_sync_q[SYNC_STAGES-1];

    // Event detection and next-state: a coincident rise shifts first so a load commits the post-shift word
    always_comb begin
        rise       = sclk & ~sclk_prev_q;
        fall_rst   = ~srst & srst_prev_q;
        load       = fall_rst & sclk;
        clear      = fall_rst & ~sclk;
        shift_post = rise ? {shift_q[CTRL_BITS-2:0], sdat} : shift_q;
`ifdef GPIO_CFG_FRAME_CHECK_EN
        cnt_post   = rise ? ((cnt_q == cnt_w'(CTRL_BITS - 1)) ? '0 : cnt_q + 1'b1) : cnt_q;
        commit     = load & (cnt_post == '0);
        cnt_d      = (load | clear) ? '0 : cnt_post;
        err_d      = err_q | (load & ~commit);
`else
        commit     = load;
`endif
        shift_d    = clear ? '0 : shift_post;
        cfg_d      = commit ? shift_post : cfg_q;
    end

    // Synchronizers, edge history and configuration state; chains reset low so release makes no edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_q <= '0;
            srst_sync_q <= '0;
            sdat_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            srst_prev_q <= 1'b0;
            shift_q     <= '0;
            cfg_q       <= DEFAULT_CFG;
            data_out_q  <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], serial_clock_in};
            srst_sync_q <= {srst_sync_q[SYNC_STAGES-2:0], serial_resetn_in};
            sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], serial_data_in};
            sclk_prev_q <= sclk;
            srst_prev_q <= srst;
            shift_q     <= shift_d;
            cfg_q       <= cfg_d;
            data_out_q  <= shift_q[CTRL_BITS-1];
            pulse_q     <= commit;
        end
    end

`ifdef GPIO_CFG_FRAME_CHECK_EN
    // Frame-length counter and sticky short-frame error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cfg_error = err_q;
`endif

    assign serial_clock_out  = sclk;
    assign serial_resetn_out = srst;
    assign serial_data_out   = data_out_q;
    assign cfg_word          = cfg_q;
    assign load_pulse        = pulse_q;

    assign mgmt_ena        = cfg_q[0];
    assign oeb             = cfg_q[1];
    assign pad_gpio_out    = mgmt_ena ? mgmt_gpio_out : user_gpio_out;
    assign pad_gpio_outenb = mgmt_ena ? oeb : user_gpio_oeb;
    assign mgmt_gpio_in    = pad_gpio_in;
    assign user_gpio_in    = mgmt_ena ? 1'b0 : pad_gpio_in;
endmodule

// File: tb/tb_gpio_cfg_receiver.sv
// tb_gpio_cfg_receiver: directed bench for a two-pad chain of gpio_cfg_receiver.
module tb_gpio_cfg_receiver;
    localparam int SYNC = 2;
`ifdef GPIO_CFG_FRAME_CHECK_EN
    localparam int CLR_BITS = 13;
`else
    localparam int CLR_BITS = 8;
`endif

    logic clk = 1'b0;
    logic resetn, sci, sri, sdi;
    logic mgmt_out, user_out, user_oeb, pad_in;
    logic sco_a, sro_a, sdo_a, sco_b, sro_b, sdo_b;
    logic [12:0] cfg_a, cfg_b;
    logic pulse_a, pulse_b;
    logic mgmt_in_a, user_in_a, pad_out_a, outenb_a;
    logic mgmt_in_b, user_in_b, pad_out_b, outenb_b;
`ifdef GPIO_CFG_FRAME_CHECK_EN
    logic err_a, err_b;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_cfg_receiver dut_a (
        .clk(clk), .resetn(resetn),
        .serial_clock_in(sci), .serial_resetn_in(sri), .serial_data_in(sdi),
        .serial_clock_out(sco_a), .serial_resetn_out(sro_a), .serial_data_out(sdo_a),
        .cfg_word(cfg_a), .load_pulse(pulse_a),
`ifdef GPIO_CFG_FRAME_CHECK_EN
        .cfg_error(err_a),
`endif
        .mgmt_gpio_out(mgmt_out), .mgmt_gpio_in(mgmt_in_a),
        .user_gpio_out(user_out), .user_gpio_oeb(user_oeb), .user_gpio_in(user_in_a),
        .pad_gpio_in(pad_in), .pad_gpio_out(pad_out_a), .pad_gpio_outenb(outenb_a)
    );

    gpio_cfg_receiver dut_b (
        .clk(clk), .resetn(resetn),
        .serial_clock_in(sco_a), .serial_resetn_in(sro_a), .serial_data_in(sdo_a),
        .serial_clock_out(sco_b), .serial_resetn_out(sro_b), .serial_data_out(sdo_b),
        .cfg_word(cfg_b), .load_pulse(pulse_b),
`ifdef GPIO_CFG_FRAME_CHECK_EN
        .cfg_error(err_b),
`endif
        .mgmt_gpio_out(mgmt_out), .mgmt_gpio_in(mgmt_in_b),
        .user_gpio_out(user_out), .user_gpio_oeb(user_oeb), .user_gpio_in(user_in_b),
        .pad_gpio_in(pad_in), .pad_gpio_out(pad_out_b), .pad_gpio_outenb(outenb_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        @(negedge clk);
        sdi = b;
        sci = 1'b0;
        @(negedge clk);
        sci = 1'b1;
    endtask

    task automatic shift_word(input logic [12:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic do_load(input bit exp_pulse);
        int lat;
        int width;
        lat = 0;
        width = 0;
        repeat (4) @(negedge clk);
        sri = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pulse_a) begin
                width++;
                if (lat == 0) lat = i;
            end
        end
        if (exp_pulse) begin
            chk("load_seen", 32'(lat != 0), 1);
            chk("load_latency_ok", 32'(lat <= SYNC + 2), 1);
            chk("load_width", width, 1);
        end else begin
            chk("no_load_pulse", width, 0);
        end
        sri = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int pulses;
        resetn = 1'b0; sci = 1'b0; sri = 1'b1; sdi = 1'b0;
        mgmt_out = 1'b0; user_out = 1'b0; user_oeb = 1'b1; pad_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cfg", cfg_a, 13'h1803);
        chk("rst_pulse", pulse_a, 0);
        chk("rst_sdo", sdo_a, 0);
        chk("rst_outenb", outenb_a, 1);
        chk("rst_user_in", user_in_a, 0);
        chk("rst_mgmt_in", mgmt_in_a, 1);
`ifdef GPIO_CFG_FRAME_CHECK_EN
        chk("rst_cfg_error", err_a, 0);
`endif
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        shift_word(13'h0403, 13);
        do_load(1);
        chk("single_cfg", cfg_a, 13'h0403);
        chk("single_outenb", outenb_a, 1);
        mgmt_out = 1'b1;
        #1 chk("single_pad_out_hi", pad_out_a, 1);
        mgmt_out = 1'b0;
        #1 chk("single_pad_out_lo", pad_out_a, 0);

        shift_word(13'h1C05, 13);
        shift_word(13'h0403, 13);
        do_load(1);
        chk("chain_cfg_b", cfg_b, 13'h1C05);
        chk("chain_cfg_a", cfg_a, 13'h0403);
        chk("chain_outenb_b", outenb_b, 0);
        mgmt_out = 1'b1;
        #1 chk("chain_pad_out_b", pad_out_b, 1);
        mgmt_out = 1'b0;

        shift_word(13'h1FFF, 5);
        @(negedge clk);
        sci = 1'b0;
        repeat (4) @(negedge clk);
        sri = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pulse_a) pulses++;
        end
        chk("clear_no_pulse", pulses, 0);
        chk("clear_cfg_kept", cfg_a, 13'h0403);
        sri = 1'b1;
        repeat (4) @(negedge clk);
        shift_word(13'h0000, CLR_BITS);
        do_load(1);
        chk("clear_then_load", cfg_a, 13'h0000);
        user_out = 1'b1; user_oeb = 1'b0; pad_in = 1'b1;
        #1 chk("user_pad_out_hi", pad_out_a, 1);
        chk("user_outenb", outenb_a, 0);
        chk("user_in_hi", user_in_a, 1);
        user_out = 1'b0; pad_in = 1'b0;
        #1 chk("user_pad_out_lo", pad_out_a, 0);
        chk("user_in_lo", user_in_a, 0);
        user_oeb = 1'b1;

        shift_word(13'h1FFF, 7);
        @(negedge clk);
        resetn = 1'b0; sci = 1'b0; sri = 1'b1;
        #1 chk("midrst_cfg", cfg_a, 13'h1803);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_cfg_after", cfg_a, 13'h1803);
        shift_word(13'h1FFF, 13);
        do_load(1);
        chk("midrst_full_frame", cfg_a, 13'h1FFF);

`ifdef GPIO_CFG_FRAME_CHECK_EN
        shift_word(13'h1FFF, 12);
        do_load(0);
        chk("short_frame_cfg", cfg_a, 13'h1FFF);
        chk("short_frame_err", err_a, 1);
        shift_word(13'h0AAA, 13);
        shift_word(13'h0555, 13);
        do_load(1);
        chk("double_frame_cfg", cfg_a, 13'h0555);
        chk("err_sticky", err_a, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
